// File: rtl/regfile_wb_arbiter.sv
// Round-robin owner of the register file write port (ALU vs long-latency unit) plus busy-bit scoreboard.
// Latency: 1 cycle from grant to RegWrite/WriteAddr/WriteData; ready and iss_stall are combinational.
// Backpressure: the loser of a tie sees ready=0 and holds; issue is held by iss_stall on RAW/WAW hazards.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_rs1Addr,
    input  logic [ADDR_W-1:0]   iss_rs2Addr,
    input  logic [ADDR_W-1:0]   iss_rdAddr,
    input  logic                iss_long,
    output logic                iss_stall,
    input  logic                alu_wb_valid,
    input  logic [ADDR_W-1:0]   alu_wb_addr,
    input  logic [DATA_W-1:0]   alu_wb_data,
    output logic                alu_wb_ready,
    input  logic                lu_wb_valid,
    input  logic [ADDR_W-1:0]   lu_wb_addr,
    input  logic [DATA_W-1:0]   lu_wb_data,
    output logic                lu_wb_ready,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   WriteAddr,
    output logic [DATA_W-1:0]   WriteData,
    output logic [NUM_REGS-1:0] sb_busy
);

    // 0 = ALU granted last, 1 = long unit granted last (reset value lets the ALU win the first tie)
    logic                last_grant;
    logic                grant_alu;
    logic                grant_lu;
    logic                xfer;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                iss_fire;
    logic [NUM_REGS-1:0] busy_next;

    // Arbitration: a lone requester wins; on a tie the one not granted last time wins
    always_comb begin
        grant_alu = alu_wb_valid && (!lu_wb_valid || last_grant);
        grant_lu  = lu_wb_valid  && (!alu_wb_valid || !last_grant);
        xfer      = grant_alu || grant_lu;
        sel_addr  = grant_lu ? lu_wb_addr : alu_wb_addr;
        sel_data  = grant_lu ? lu_wb_data : alu_wb_data;
    end

    assign alu_wb_ready = grant_alu;
    assign lu_wb_ready  = grant_lu;

    // Hazard check uses registered busy bits only; bit 0 is never set so x0 never stalls
    assign iss_stall = iss_valid &&
                       (sb_busy[iss_rs1Addr] || sb_busy[iss_rs2Addr] || sb_busy[iss_rdAddr]);

    assign iss_fire = iss_valid && !iss_stall && iss_long && (iss_rdAddr != '0);

    // Scoreboard next state: long-unit writeback clears, long issue sets, set applied last so it wins
    always_comb begin
        busy_next = sb_busy;
        if (grant_lu) begin
            busy_next[lu_wb_addr] = 1'b0;
        end
        if (iss_fire) begin
            busy_next[iss_rdAddr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Write port register, grant history and scoreboard state
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite   <= 1'b0;
            WriteAddr  <= '0;
            WriteData  <= '0;
            sb_busy    <= '0;
            last_grant <= 1'b1;
        end else begin
            RegWrite <= xfer && (sel_addr != '0);
            if (xfer) begin
                WriteAddr  <= sel_addr;
                WriteData  <= sel_data;
                last_grant <= grant_lu;
            end
            sb_busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: writeback arbitration, output timing and scoreboard stalls.
// Inputs driven 1 time unit after the rising edge; outputs compared before the next edge.
// Every expectation is a hand-computed constant.
module tb_regfile_wb_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                iss_valid;
    logic [ADDR_W-1:0]   iss_rs1Addr;
    logic [ADDR_W-1:0]   iss_rs2Addr;
    logic [ADDR_W-1:0]   iss_rdAddr;
    logic                iss_long;
    logic                iss_stall;
    logic                alu_wb_valid;
    logic [ADDR_W-1:0]   alu_wb_addr;
    logic [DATA_W-1:0]   alu_wb_data;
    logic                alu_wb_ready;
    logic                lu_wb_valid;
    logic [ADDR_W-1:0]   lu_wb_addr;
    logic [DATA_W-1:0]   lu_wb_data;
    logic                lu_wb_ready;
    logic                RegWrite;
    logic [ADDR_W-1:0]   WriteAddr;
    logic [DATA_W-1:0]   WriteData;
    logic [NUM_REGS-1:0] sb_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rs1Addr(iss_rs1Addr), .iss_rs2Addr(iss_rs2Addr),
        .iss_rdAddr(iss_rdAddr), .iss_long(iss_long), .iss_stall(iss_stall),
        .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
        .alu_wb_ready(alu_wb_ready),
        .lu_wb_valid(lu_wb_valid), .lu_wb_addr(lu_wb_addr), .lu_wb_data(lu_wb_data),
        .lu_wb_ready(lu_wb_ready),
        .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData), .sb_busy(sb_busy)
    );

    // Advance one clock and settle one unit past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid    = 1'b0;
        iss_rs1Addr  = '0;
        iss_rs2Addr  = '0;
        iss_rdAddr   = '0;
        iss_long     = 1'b0;
        alu_wb_valid = 1'b0;
        alu_wb_addr  = '0;
        alu_wb_data  = '0;
        lu_wb_valid  = 1'b0;
        lu_wb_addr   = '0;
        lu_wb_data   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
        total++; if (WriteAddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d exp=0", WriteAddr); end
        total++; if (WriteData !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", WriteData); end
        total++; if (sb_busy !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h exp=0", sb_busy); end
        total++; if (iss_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", iss_stall); end
    endtask

    task automatic test_alu_write();
        alu_wb_valid = 1'b1;
        alu_wb_addr  = 5'd5;
        alu_wb_data  = 32'hA5A5A5A5;
        #1;
        total++; if (alu_wb_ready !== 1'b1) begin bad++; $display("FAIL alu_ready got=%b exp=1", alu_wb_ready); end
        total++; if (lu_wb_ready !== 1'b0) begin bad++; $display("FAIL alu_lu_ready got=%b exp=0", lu_wb_ready); end
        tick();
        alu_wb_valid = 1'b0;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL alu_regwrite got=%b exp=1", RegWrite); end
        total++; if (WriteAddr !== 5'd5) begin bad++; $display("FAIL alu_waddr got=%0d exp=5", WriteAddr); end
        total++; if (WriteData !== 32'hA5A5A5A5) begin bad++; $display("FAIL alu_wdata got=%h exp=a5a5a5a5", WriteData); end
        tick();
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL alu_regwrite_drop got=%b exp=0", RegWrite); end
        total++; if (WriteAddr !== 5'd5) begin bad++; $display("FAIL alu_waddr_hold got=%0d exp=5", WriteAddr); end
        total++; if (WriteData !== 32'hA5A5A5A5) begin bad++; $display("FAIL alu_wdata_hold got=%h exp=a5a5a5a5", WriteData); end
    endtask

    task automatic test_back_to_back();
        logic       exp_alu;
        logic [4:0] exp_addr;
        logic [31:0] exp_data;
        do_reset();
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd3; alu_wb_data = 32'h0000_0333;
        lu_wb_valid  = 1'b1; lu_wb_addr  = 5'd7; lu_wb_data  = 32'h0000_0777;
        for (int i = 0; i < 4; i++) begin
            exp_alu  = (i % 2 == 0);
            exp_addr = exp_alu ? 5'd3 : 5'd7;
            exp_data = exp_alu ? 32'h0000_0333 : 32'h0000_0777;
            #1;
            total++; if (alu_wb_ready !== exp_alu) begin bad++; $display("FAIL rr_alu_ready[%0d] got=%b exp=%b", i, alu_wb_ready, exp_alu); end
            total++; if (lu_wb_ready !== !exp_alu) begin bad++; $display("FAIL rr_lu_ready[%0d] got=%b exp=%b", i, lu_wb_ready, !exp_alu); end
            tick();
            total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL rr_regwrite[%0d] got=%b exp=1", i, RegWrite); end
            total++; if (WriteAddr !== exp_addr) begin bad++; $display("FAIL rr_waddr[%0d] got=%0d exp=%0d", i, WriteAddr, exp_addr); end
            total++; if (WriteData !== exp_data) begin bad++; $display("FAIL rr_wdata[%0d] got=%h exp=%h", i, WriteData, exp_data); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_long = 1'b1; iss_rdAddr = 5'd9;
        #1;
        total++; if (iss_stall !== 1'b0) begin bad++; $display("FAIL sb_issue_stall got=%b exp=0", iss_stall); end
        tick();
        total++; if (sb_busy !== 32'h0000_0200) begin bad++; $display("FAIL sb_set9 got=%h exp=00000200", sb_busy); end
        iss_long = 1'b0; iss_rdAddr = 5'd10; iss_rs1Addr = 5'd9;
        #1;
        total++; if (iss_stall !== 1'b1) begin bad++; $display("FAIL sb_raw_stall got=%b exp=1", iss_stall); end
        tick();
        total++; if (iss_stall !== 1'b1) begin bad++; $display("FAIL sb_raw_stall_hold got=%b exp=1", iss_stall); end
        lu_wb_valid = 1'b1; lu_wb_addr = 5'd9; lu_wb_data = 32'hDEAD_0009;
        #1;
        total++; if (lu_wb_ready !== 1'b1) begin bad++; $display("FAIL sb_lu_ready got=%b exp=1", lu_wb_ready); end
        total++; if (iss_stall !== 1'b1) begin bad++; $display("FAIL sb_stall_same_cycle got=%b exp=1", iss_stall); end
        tick();
        lu_wb_valid = 1'b0;
        #1;
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL sb_regwrite got=%b exp=1", RegWrite); end
        total++; if (WriteAddr !== 5'd9) begin bad++; $display("FAIL sb_waddr got=%0d exp=9", WriteAddr); end
        total++; if (WriteData !== 32'hDEAD_0009) begin bad++; $display("FAIL sb_wdata got=%h exp=dead0009", WriteData); end
        total++; if (sb_busy !== 32'd0) begin bad++; $display("FAIL sb_clear9 got=%h exp=0", sb_busy); end
        total++; if (iss_stall !== 1'b0) begin bad++; $display("FAIL sb_stall_release got=%b exp=0", iss_stall); end
        // WAW: busy destination also stalls
        idle_inputs();
        iss_valid = 1'b1; iss_long = 1'b1; iss_rdAddr = 5'd17;
        tick();
        iss_long = 1'b0; iss_rdAddr = 5'd17; iss_rs1Addr = 5'd1; iss_rs2Addr = 5'd2;
        #1;
        total++; if (iss_stall !== 1'b1) begin bad++; $display("FAIL sb_waw_stall got=%b exp=1", iss_stall); end
        iss_rdAddr = 5'd18; iss_rs2Addr = 5'd17;
        #1;
        total++; if (iss_stall !== 1'b1) begin bad++; $display("FAIL sb_rs2_stall got=%b exp=1", iss_stall); end
        idle_inputs();
        lu_wb_valid = 1'b1; lu_wb_addr = 5'd17;
        tick();
        idle_inputs();
        total++; if (sb_busy !== 32'd0) begin bad++; $display("FAIL sb_clear17 got=%h exp=0", sb_busy); end
    endtask

    task automatic test_x0();
        iss_valid = 1'b1; iss_long = 1'b1; iss_rdAddr = 5'd0;
        #1;
        total++; if (iss_stall !== 1'b0) begin bad++; $display("FAIL x0_stall got=%b exp=0", iss_stall); end
        tick();
        idle_inputs();
        total++; if (sb_busy !== 32'd0) begin bad++; $display("FAIL x0_busy got=%h exp=0", sb_busy); end
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd0; alu_wb_data = 32'h1234_5678;
        #1;
        total++; if (alu_wb_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", alu_wb_ready); end
        tick();
        idle_inputs();
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL x0_regwrite got=%b exp=0", RegWrite); end
    endtask

    task automatic test_same_edge();
        iss_valid = 1'b1; iss_long = 1'b1; iss_rdAddr = 5'd12;
        lu_wb_valid = 1'b1; lu_wb_addr = 5'd12; lu_wb_data = 32'h0000_00CC;
        #1;
        total++; if (lu_wb_ready !== 1'b1) begin bad++; $display("FAIL se_lu_ready got=%b exp=1", lu_wb_ready); end
        total++; if (iss_stall !== 1'b0) begin bad++; $display("FAIL se_stall got=%b exp=0", iss_stall); end
        tick();
        idle_inputs();
        total++; if (sb_busy !== 32'h0000_1000) begin bad++; $display("FAIL se_busy12 got=%h exp=00001000", sb_busy); end
        total++; if (RegWrite !== 1'b1 || WriteAddr !== 5'd12) begin bad++; $display("FAIL se_write got=%b/%0d exp=1/12", RegWrite, WriteAddr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        iss_valid = 1'b1; iss_long = 1'b1; iss_rdAddr = 5'd4;
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd6; alu_wb_data = 32'h0000_0066;
        tick();
        idle_inputs();
        total++; if (sb_busy !== 32'h0000_0010) begin bad++; $display("FAIL rm_busy4 got=%h exp=00000010", sb_busy); end
        // ALU just won, so without reset the long unit would win the next tie
        rst = 1'b1;
        lu_wb_valid = 1'b1; lu_wb_addr = 5'd4; lu_wb_data = 32'h0000_0044;
        #1;
        total++; if (lu_wb_ready !== 1'b1) begin bad++; $display("FAIL rm_ready_in_reset got=%b exp=1", lu_wb_ready); end
        tick();
        rst = 1'b0;
        idle_inputs();
        total++; if (sb_busy !== 32'd0) begin bad++; $display("FAIL rm_busy got=%h exp=0", sb_busy); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL rm_regwrite got=%b exp=0", RegWrite); end
        total++; if (WriteAddr !== 5'd0) begin bad++; $display("FAIL rm_waddr got=%0d exp=0", WriteAddr); end
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd1;
        lu_wb_valid  = 1'b1; lu_wb_addr  = 5'd2;
        #1;
        total++; if (alu_wb_ready !== 1'b1 || lu_wb_ready !== 1'b0) begin bad++; $display("FAIL rm_last_grant got=%b%b exp=10", alu_wb_ready, lu_wb_ready); end
        tick();
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_alu_write();
        test_back_to_back();
        test_scoreboard();
        test_x0();
        test_same_edge();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
